// File: rtl/softmax_pkg.sv
// softmax_pkg: shared constants and types for the softmax datapath.
//   LANES / DW      frame geometry (lanes per frame, lane width in bits)
//   ONE_Q15         1.0 in unsigned Q1.15
//   length_mode_e   segment modes (LM_64, LM_32, LM_16)
//   decode_mode     maps the raw 4-bit mode code; unknown codes fall back to LM_64
package softmax_pkg;

  localparam int LANES = 64;
  localparam int DW    = 16;

  localparam logic [15:0] ONE_Q15 = 16'h8000;

  typedef enum logic [3:0] {
    LM_64 = 4'd0,
    LM_32 = 4'd1,
    LM_16 = 4'd2
  } length_mode_e;

  function automatic length_mode_e decode_mode(input logic [3:0] code);
    case (code)
      4'd1:    return LM_32;
      4'd2:    return LM_16;
      default: return LM_64;
    endcase
  endfunction

endpackage

// File: rtl/exp2_lane.sv
// exp2_lane: one lane of the exponent pipeline (three register stages).
//   S1: d = sat(x - max) to [-32768, 0]; masked lanes load d = -32768 (forces output 0)
//   S2: t = d + (d >>> 1) - (d >>> 4)   (d * log2(e) approximation)
//   S3: 2^t with integer part i = floor(t/256), fraction f = t[7:0], result unsigned Q1.15
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_en           advance enable; all stages hold when low
//   i_mask         lane valid bit
//   i_x, i_max     signed Q8.8 score and its segment maximum
//   o_exp          registered exponent, unsigned Q1.15
module exp2_lane
  import softmax_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  input  logic        i_mask,
  input  logic [15:0] i_x,
  input  logic [15:0] i_max,
  output logic [15:0] o_exp
);

  localparam logic signed [16:0] DMin = -17'sd32768;

  logic signed [16:0] diff;
  logic signed [15:0] d_d, d_q;
  logic signed [17:0] d_ext;
  logic signed [17:0] t_d, t_q;
  logic signed [9:0]  int_part;
  logic signed [9:0]  neg_i;
  logic [15:0]        mant;
  logic [15:0]        exp_d, exp_q;

  always_comb begin
    diff = $signed({i_x[15], i_x}) - $signed({i_max[15], i_max});
    if (!i_mask) begin
      d_d = 16'sh8000;
    end else if (diff > 17'sd0) begin
      d_d = 16'sh0000;
    end else if (diff < DMin) begin
      d_d = 16'sh8000;
    end else begin
      d_d = diff[15:0];
    end
  end

  always_comb begin
    d_ext = $signed({{2{d_q[15]}}, d_q});
    t_d   = d_ext + (d_ext >>> 1) - (d_ext >>> 4);
  end

  // t <= 0, so the integer part is <= 0 and the shift amount is -i >= 0.
  always_comb begin
    int_part = t_q[17:8];
    neg_i    = -int_part;
    mant     = ONE_Q15 + {1'b0, t_q[7:0], 7'b0};
    if (neg_i >= 10'sd16) begin
      exp_d = 16'h0000;
    end else begin
      exp_d = mant >> neg_i[3:0];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      d_q   <= '0;
      t_q   <= '0;
      exp_q <= '0;
    end else if (i_en) begin
      d_q   <= d_d;
      t_q   <= t_d;
      exp_q <= exp_d;
    end
  end

  assign o_exp = exp_q;

endmodule

// File: rtl/sub_exp_stage.sv
// sub_exp_stage: per-lane exponent stage of the softmax pipeline.
// Subtracts the per-segment maximum from each lane and evaluates exp() as a
// Q1.15 power of two. Latency is 3 enabled cycles (4 with SUB_EXP_SUM_EN).
// Optional feature macro: SUB_EXP_SUM_EN adds a fourth stage producing
// o_sum16_0..3, the sums of each 16-lane quarter of the exponent frame.
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_en                pipeline advance (0 = stall everything)
//   i_valid_max         frame valid from the max stage
//   i_length_mode       0: one 64-lane segment, 1: two 32-lane, 2: four 16-lane
//   i_in_flat           lane scores, signed Q8.8, lane k at [16k+15:16k]
//   i_lane_mask         per-lane valid mask
//   i_global_max, i_max32_*, i_max16_*  segment maxima
//   o_valid_exp, o_exp_flat             output valid and lane exponents (Q1.15)
//   o_length_mode_byp, o_lane_mask_byp  mode and mask aligned with o_exp_flat
module sub_exp_stage #(
  parameter int LANES = softmax_pkg::LANES,
  parameter int DW    = softmax_pkg::DW
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_en,
  input  logic                i_valid_max,
  input  logic [3:0]          i_length_mode,
  input  logic [LANES*DW-1:0] i_in_flat,
  input  logic [LANES-1:0]    i_lane_mask,
  input  logic [DW-1:0]       i_global_max,
  input  logic [DW-1:0]       i_max32_0,
  input  logic [DW-1:0]       i_max32_1,
  input  logic [DW-1:0]       i_max16_0,
  input  logic [DW-1:0]       i_max16_1,
  input  logic [DW-1:0]       i_max16_2,
  input  logic [DW-1:0]       i_max16_3,
  output logic                o_valid_exp,
  output logic [LANES*DW-1:0] o_exp_flat,
  output logic [3:0]          o_length_mode_byp,
  output logic [LANES-1:0]    o_lane_mask_byp
`ifdef SUB_EXP_SUM_EN
  ,
  output logic [19:0]         o_sum16_0,
  output logic [19:0]         o_sum16_1,
  output logic [19:0]         o_sum16_2,
  output logic [19:0]         o_sum16_3
`endif
);

  import softmax_pkg::*;

`ifdef SUB_EXP_SUM_EN
  localparam int Latency = 4;
`else
  localparam int Latency = 3;
`endif

  length_mode_e                mode;
  logic [LANES-1:0][15:0]      lane_max;
  logic [LANES-1:0][15:0]      lane_exp;
  logic [3:0][15:0]            max16;

  always_comb begin
    mode  = decode_mode(i_length_mode);
    max16 = {i_max16_3, i_max16_2, i_max16_1, i_max16_0};
    for (int k = 0; k < LANES; k++) begin
      case (mode)
        LM_32:   lane_max[k] = (k < LANES / 2) ? i_max32_0 : i_max32_1;
        LM_16:   lane_max[k] = max16[2'(k / (LANES / 4))];
        default: lane_max[k] = i_global_max;
      endcase
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    exp2_lane u_lane (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_en   (i_en),
      .i_mask (i_lane_mask[k]),
      .i_x    (i_in_flat[k*DW +: 16]),
      .i_max  (lane_max[k]),
      .o_exp  (lane_exp[k])
    );
  end

  // Side-band delay lines; data is never squashed, only qualified by valid.
  logic [Latency-1:0]            valid_d, valid_q;
  logic [Latency-1:0][3:0]       mode_d, mode_q;
  logic [Latency-1:0][LANES-1:0] mask_d, mask_q;

  always_comb begin
    valid_d = {valid_q[Latency-2:0], i_valid_max};
    mode_d  = {mode_q[Latency-2:0], i_length_mode};
    mask_d  = {mask_q[Latency-2:0], i_lane_mask};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q <= '0;
      mode_q  <= '0;
      mask_q  <= '0;
    end else if (i_en) begin
      valid_q <= valid_d;
      mode_q  <= mode_d;
      mask_q  <= mask_d;
    end
  end

  assign o_valid_exp       = valid_q[Latency-1];
  assign o_length_mode_byp = mode_q[Latency-1];
  assign o_lane_mask_byp   = mask_q[Latency-1];

`ifdef SUB_EXP_SUM_EN
  logic [LANES-1:0][15:0] exp4_d, exp4_q;
  logic [3:0][19:0]       sum_d, sum_q;

  always_comb begin
    exp4_d = lane_exp;
    sum_d  = '0;
    for (int j = 0; j < 4; j++) begin
      for (int l = 0; l < 16; l++) begin
        sum_d[j] = sum_d[j] + 20'(lane_exp[16*j+l]);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      exp4_q <= '0;
      sum_q  <= '0;
    end else if (i_en) begin
      exp4_q <= exp4_d;
      sum_q  <= sum_d;
    end
  end

  assign o_exp_flat = exp4_q;
  assign o_sum16_0  = sum_q[0];
  assign o_sum16_1  = sum_q[1];
  assign o_sum16_2  = sum_q[2];
  assign o_sum16_3  = sum_q[3];
`else
  assign o_exp_flat = lane_exp;
`endif

endmodule

// File: tb/tb_sub_exp_stage.sv
// Directed bench for sub_exp_stage: reset, exp values, boundaries, modes, stall, reset.
module tb_sub_exp_stage;

`ifdef SUB_EXP_SUM_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic          clk = 1'b0;
  logic          rst, en, valid;
  logic [3:0]    mode;
  logic [1023:0] flat;
  logic [63:0]   mask;
  logic [15:0]   gmax, m32_0, m32_1, m16_0, m16_1, m16_2, m16_3;
  logic          o_valid;
  logic [1023:0] o_flat;
  logic [3:0]    o_mode;
  logic [63:0]   o_mask;
`ifdef SUB_EXP_SUM_EN
  logic [19:0]   o_sum0, o_sum1, o_sum2, o_sum3;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sub_exp_stage dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_en              (en),
    .i_valid_max       (valid),
    .i_length_mode     (mode),
    .i_in_flat         (flat),
    .i_lane_mask       (mask),
    .i_global_max      (gmax),
    .i_max32_0         (m32_0),
    .i_max32_1         (m32_1),
    .i_max16_0         (m16_0),
    .i_max16_1         (m16_1),
    .i_max16_2         (m16_2),
    .i_max16_3         (m16_3),
    .o_valid_exp       (o_valid),
    .o_exp_flat        (o_flat),
    .o_length_mode_byp (o_mode),
    .o_lane_mask_byp   (o_mask)
`ifdef SUB_EXP_SUM_EN
    ,
    .o_sum16_0         (o_sum0),
    .o_sum16_1         (o_sum1),
    .o_sum16_2         (o_sum2),
    .o_sum16_3         (o_sum3)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Sample one frame, then let it travel to the output with valid low behind it.
  task automatic run_frame();
    step();
    valid = 1'b0;
    steps(LAT - 1);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_flat(input string tag, input logic [1023:0] exp);
    int bad;
    checks++;
    assert (o_flat === exp) else begin
      errors++;
      bad = 0;
      for (int k = 63; k >= 0; k--) if (o_flat[16*k +: 16] !== exp[16*k +: 16]) bad = k;
      $error("FAIL %s: lane %0d got 0x%04h expected 0x%04h", tag, bad,
             o_flat[16*bad +: 16], exp[16*bad +: 16]);
    end
  endtask

  function automatic logic [1023:0] fill(input logic [15:0] v);
    return {64{v}};
  endfunction

  logic [1023:0] exp_flat;

  initial begin
    // Busy inputs during reset so zero outputs are due to reset alone.
    rst = 1'b1; en = 1'b1; valid = 1'b1; mode = 4'd2; mask = '1;
    flat = fill(16'h0100); gmax = 16'h0100;
    m32_0 = 16'h0100; m32_1 = 16'h0100;
    m16_0 = 16'h0100; m16_1 = 16'h0100; m16_2 = 16'h0100; m16_3 = 16'h0100;
    steps(LAT + 1);
    chk("rst_valid", o_valid, 0);
    chk_flat("rst_exp", '0);
    chk("rst_mode", o_mode, 0);
    chk("rst_mask", o_mask, 0);
    rst = 1'b0; valid = 1'b0; mode = 4'd0;

    // All lanes equal to the global max -> 1.0 everywhere, exact latency.
    flat = fill(16'h0100); gmax = 16'h0100; mask = '1; valid = 1'b1;
    step();
    valid = 1'b0;
    steps(LAT - 2);
    chk("lat_early", o_valid, 0);
    step();
    chk("a_valid", o_valid, 1);
    chk_flat("a_exp", fill(16'h8000));
    chk("a_mode", o_mode, 0);
    chk("a_mask", o_mask, 64'hFFFF_FFFF_FFFF_FFFF);
`ifdef SUB_EXP_SUM_EN
    chk("a_sum0", o_sum0, 20'h80000);
    chk("a_sum3", o_sum3, 20'h80000);
`endif

    // Hand-computed points around gmax = 0x0100.
    flat = fill(16'h0100);
    flat[16*0 +: 16] = 16'h0000;  // d=-256,  t=-368,  i=-2  f=144 -> 0x3200
    flat[16*1 +: 16] = 16'hF700;  // d=-2560, t=-3680, i=-15 f=160 -> 0x0001
    flat[16*2 +: 16] = 16'hF680;  // d=-2688, t=-3864, i=-16      -> 0x0000
    flat[16*3 +: 16] = 16'h0200;  // x > max clamps d to 0        -> 0x8000
    flat[16*4 +: 16] = 16'h00FE;  // d=-2,    t=-2,    i=-1 f=254 -> 0x7F80
    valid = 1'b1;
    run_frame();
    exp_flat = fill(16'h8000);
    exp_flat[16*0 +: 16] = 16'h3200;
    exp_flat[16*1 +: 16] = 16'h0001;
    exp_flat[16*2 +: 16] = 16'h0000;
    exp_flat[16*4 +: 16] = 16'h7F80;
    chk("b_lane0", o_flat[15:0], 16'h3200);
    chk("b_shift15", o_flat[31:16], 16'h0001);
    chk("b_shift16", o_flat[47:32], 16'h0000);
    chk("b_pos_clamp", o_flat[63:48], 16'h8000);
    chk_flat("b_exp", exp_flat);

    // Saturation and masking.
    flat = fill(16'h7FFF); flat[15:0] = 16'h8000; gmax = 16'h7FFF;
    mask = ~64'h2; valid = 1'b1;
    run_frame();
    exp_flat = fill(16'h8000);
    exp_flat[15:0] = 16'h0000;
    exp_flat[31:16] = 16'h0000;
    chk("c_sat", o_flat[15:0], 16'h0000);
    chk("c_masked", o_flat[31:16], 16'h0000);
    chk_flat("c_exp", exp_flat);
    chk("c_mask_byp", o_mask, ~64'h2);
    mask = '1;

    // Two 32-lane segments.
    mode = 4'd1; flat = fill(16'h0200); gmax = 16'h7FFF;
    m32_0 = 16'h0200; m32_1 = 16'h0300; valid = 1'b1;
    run_frame();
    chk_flat("m1_exp", {{32{16'h3200}}, {32{16'h8000}}});
    chk("m1_mode", o_mode, 1);

    // Four 16-lane segments.
    mode = 4'd2; m32_0 = 16'h7FFF; m32_1 = 16'h7FFF;
    m16_0 = 16'h0200; m16_1 = 16'h0300; m16_2 = 16'h0280; m16_3 = 16'h0400;
    valid = 1'b1;
    run_frame();
    chk_flat("m2_exp", {{16{16'h1200}}, {16{16'h5200}}, {16{16'h3200}}, {16{16'h8000}}});
    chk("m2_mode", o_mode, 2);

    // Unknown mode code behaves like a single 64-lane segment.
    mode = 4'd5; gmax = 16'h0200; valid = 1'b1;
    run_frame();
    chk_flat("m5_exp", fill(16'h8000));
    chk("m5_mode", o_mode, 5);

    // Three back-to-back frames, stall mid-flight, then drain.
    mode = 4'd0; flat = fill(16'h0100); valid = 1'b1;
    gmax = 16'h0100; step();
    gmax = 16'h0200; mode = 4'd3; step();
    gmax = 16'h0180; mode = 4'd0; step();
    valid = 1'b0;
    steps(LAT - 3);
    chk("s_f1_valid", o_valid, 1);
    chk_flat("s_f1_exp", fill(16'h8000));
    en = 1'b0;
    steps(5);
    chk("s_hold_valid", o_valid, 1);
    chk_flat("s_hold_exp", fill(16'h8000));
    chk("s_hold_mode", o_mode, 0);
    en = 1'b1;
    step();
    chk("s_f2_valid", o_valid, 1);
    chk_flat("s_f2_exp", fill(16'h3200));
    chk("s_f2_mode", o_mode, 3);
    step();
    chk("s_f3_valid", o_valid, 1);
    chk_flat("s_f3_exp", fill(16'h5200));
    chk("s_f3_mode", o_mode, 0);
    step();
    chk("s_drain_valid", o_valid, 0);

    // Reset with two frames in flight.
    mode = 4'd2; gmax = 16'h0100; m16_0 = 16'h0100; m16_1 = 16'h0100;
    m16_2 = 16'h0100; m16_3 = 16'h0100; mask = '1; valid = 1'b1;
    step(); step();
    valid = 1'b0;
    steps(LAT - 2);
    chk("r_pre_valid", o_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("r_async_valid", o_valid, 0);
    chk_flat("r_async_exp", '0);
    chk("r_async_mode", o_mode, 0);
    chk("r_async_mask", o_mask, 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < LAT + 1; i++) begin
      step();
      chk("r_no_stale", o_valid, 0);
    end
    mode = 4'd0; flat = fill(16'h0100); gmax = 16'h0200; valid = 1'b1;
    run_frame();
    chk("r_fresh_valid", o_valid, 1);
    chk_flat("r_fresh_exp", fill(16'h3200));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sub_exp_stage.md
SUB_EXP_STAGE -- requirements
Module: sub_exp_stage

Interface
REQ-001 Parameter: LANES, default 64, number of 16-bit lanes per frame.
REQ-002 Parameter: DW, default 16, lane data width (signed Q8.8 input).
REQ-003 Port: i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: i_rst  input  1  reset, asynchronous and active-high.
REQ-005 Port: i_en  input  1  pipeline advance enable; 0 = global stall.
REQ-006 Port: i_valid_max  input  1  frame-valid qualifier from the max stage.
REQ-007 Port: i_length_mode  input  4  segment mode: 0 = one 64-lane segment, 1 = two 32-lane, 2 = four 16-lane; other codes handled as 0.
REQ-008 Port: i_in_flat  input  1024  bypassed lane scores, lane k at bits [16k+15:16k].
REQ-009 Port: i_lane_mask  input  64  per-lane valid mask, aligned with i_in_flat.
REQ-010 Port: i_global_max, i_max32_0..1, i_max16_0..3  input  16 each  segment maxima from the max stage.
REQ-011 Port: o_valid_exp  output  1  output frame valid.
REQ-012 Port: o_exp_flat  output  1024  per-lane exponent, unsigned Q1.15 (1.0 = 0x8000).
REQ-013 Port: o_length_mode_byp  output  4  i_length_mode delayed to align with o_exp_flat.
REQ-014 Port: o_lane_mask_byp  output  64  i_lane_mask delayed to align with o_exp_flat.

Function
REQ-015 Per-lane max select: mode 0 -> i_global_max; mode 1 -> i_max32_0 for lanes 0-31 and i_max32_1 for lanes 32-63; mode 2 -> i_max16_j for lanes 16j..16j+15.
REQ-016 S1 (stage 1) SHALL compute d = x - max in 17-bit signed arithmetic, saturate to [-32768, 0], and register d.
REQ-017 S2 SHALL compute t = d + (d>>>1) - (d>>>4) in 18-bit signed arithmetic (approximates d*log2(e)) and register t.
REQ-018 S3 SHALL set i = floor(t/256) and f = t[7:0], form m = 0x8000 + (f<<7), then output m >> (-i); if -i >= 16 the output SHALL be 0x0000.
REQ-019 A lane with mask bit 0 SHALL output 0x0000 regardless of data.
REQ-020 Latency is exactly 3 enabled cycles from input sample to o_valid_exp/o_exp_flat.
REQ-021 When i_en = 0, every pipeline register, including valid, mode and mask delay registers, SHALL hold its value.
REQ-022 The valid pipeline SHALL shift i_valid_max unconditionally when i_en = 1; data registers load regardless of valid (no bubble squashing) but are ignored while valid = 0.
REQ-023 Back-to-back frames with i_en held at 1 SHALL be accepted every cycle (throughput 1 frame/cycle).

Reset
REQ-024 While i_rst = 1, all valid bits, o_exp_flat, o_length_mode_byp and o_lane_mask_byp SHALL read 0, independent of i_clk.
REQ-025 Reset asserted mid-frame SHALL discard all in-flight frames; the first output after release SHALL be a frame sampled after release.

Configuration
REQ-026 With macro SUB_EXP_SUM_EN defined: a stage S4 SHALL be added producing o_sum16_0..3 (20-bit unsigned sums of lanes 16j..16j+15 of the S3 result), latency becomes 4 for all outputs, and o_valid_exp is delayed accordingly.
REQ-027 Without SUB_EXP_SUM_EN: the o_sum16_* ports and S4 SHALL be absent and latency SHALL be 3.

Structure
REQ-028 Shared package softmax_pkg SHALL hold LANES, DW, the Q-format constants (ONE_Q15 = 0x8000) and the length-mode enum (LM_64, LM_32, LM_16).
REQ-029 Per-lane S1-S3 datapath SHALL be sub-module exp2_lane (one pipeline slice, driven by shared i_en/i_rst), instantiated LANES times by generate.

Verification
REQ-030 Mode 0, all lanes x = global max = 0x0100, mask all ones -> 3 cycles later every lane reads 0x8000 and o_valid_exp = 1.
REQ-031 Lane 0 x = 0x0000, global max = 0x0100 (d = -1.0) -> t = -368, i = -2, f = 144, lane 0 output 0x3200.
REQ-032 x = 0x8000, max = 0x7FFF -> d saturates to -32768 and output is 0x0000; mask bit 0 with x = max -> 0x0000.
REQ-033 Mode 1 with i_max32_0 = 0x0200, i_max32_1 = 0x0300, all x = 0x0200 -> lanes 0-31 read 0x8000 and lanes 32-63 read 0x3200. Mode 2 uses i_max16_j on each quarter.
REQ-034 Stall: three frames in, i_en = 0 for 5 cycles mid-flight, then 1 -> frames emerge in order, unchanged, with no loss or duplication.
REQ-035 Reset pulse with 2 frames in flight -> outputs are 0 immediately; no stale frame appears after release.
REQ-036 With SUB_EXP_SUM_EN defined, 16 lanes of 0x8000 -> o_sum16_0 = 0x80000 at latency 4.
